// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci capture controller.
// MAX_N is the largest index whose term still fits in the generator width.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_SEQ   = 2'd2;

    // F(47) is the last term below 2**32, F(93) the last below 2**64.
    function automatic int max_n_for(input int width);
        case (width)
            32:      return 47;
            64:      return 93;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/fib_nth_capture_if.sv
// Request/result bus of the Fibonacci capture controller.
// Handshake: the result transfers on any rising clock edge where result_valid && result_ready.
interface fib_nth_capture_if #(
    parameter int WIDTH = 32,
    parameter int NW    = 6
) ();

    logic             start;
    logic [NW-1:0]    n;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic [1:0]       err;

    modport master (
        output start, n, result_ready,
        input  busy, result, result_valid, err
    );

    modport slave (
        input  start, n, result_ready,
        output busy, result, result_valid, err
    );

endinterface

// File: rtl/fib_nth_capture.sv
// Clears an external Fibonacci generator, counts its terms and captures F(n),
// with range checking of n and detection of a generator that stops advancing.
module fib_nth_capture
    import fib_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int NW           = 6,
    parameter int MAX_N        = max_n_for(WIDTH),
    parameter int CLEAR_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    fib_nth_capture_if.slave   bus,
    output logic               gen_clear,
    input  logic [WIDTH-1:0]   gen_value,
    output state_t             state_dbg
);

    localparam int             CLR_LAST_I = CLEAR_CYCLES - 1;
    localparam logic [NW-1:0]  MAX_N_V    = MAX_N[NW-1:0];
    localparam logic [NW-1:0]  CLR_LAST   = CLR_LAST_I[NW-1:0];
    localparam logic [NW-1:0]  IDX_ONE    = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0]  IDX_SEQ    = 3;

    state_t           state_q, state_d;
    logic [NW-1:0]    n_q, n_d;
    logic [NW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       err_q, err_d;
    logic             gen_clear_q;
    logic             valid_q;
    logic             busy_q;

    // idx doubles as the clear-phase cycle counter and is reloaded with 1 on entry to RUN.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        idx_d    = idx_q;
        prev_d   = prev_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d = bus.n;
                    if (bus.n == '0) begin
                        state_d  = HOLD;
                        result_d = '0;
                        err_d    = ERR_OK;
                    end else if (bus.n > MAX_N_V) begin
                        state_d  = HOLD;
                        result_d = '0;
                        err_d    = ERR_RANGE;
                    end else begin
                        state_d = CLEAR;
                        idx_d   = '0;
                    end
                end
            end
            CLEAR: begin
                if (idx_q == CLR_LAST) begin
                    state_d = RUN;
                    idx_d   = IDX_ONE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            RUN: begin
                // F(1)=F(2), so strict growth is only expected from the third term on.
                if (idx_q >= IDX_SEQ && gen_value <= prev_q) begin
                    state_d  = HOLD;
                    result_d = gen_value;
                    err_d    = ERR_SEQ;
                end else if (idx_q == n_q) begin
                    state_d  = HOLD;
                    result_d = gen_value;
                    err_d    = ERR_OK;
                end else begin
                    idx_d  = idx_q + IDX_ONE;
                    prev_d = gen_value;
                end
            end
            HOLD: begin
                if (valid_q && bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            prev_q      <= '0;
            result_q    <= '0;
            err_q       <= ERR_OK;
            gen_clear_q <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
            result_q    <= result_d;
            err_q       <= err_d;
            gen_clear_q <= (state_d == CLEAR);
            valid_q     <= (state_d == HOLD);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign gen_clear        = gen_clear_q;
    assign bus.result_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.err          = err_q;
    assign state_dbg        = state_q;

`ifndef SYNTHESIS
    // A stalled result must not move until the consumer takes it.
    a_hold_stable: assert property (
        @(posedge clock) disable iff (reset)
        (valid_q && !bus.result_ready) |=> (valid_q && $stable(result_q) && $stable(err_q))
    );
    a_clear_only_in_clear: assert property (
        @(posedge clock) disable iff (reset)
        gen_clear_q |-> (state_q == CLEAR)
    );
`endif

endmodule

// File: tb/tb_fib_nth_capture.sv
// Bench for fib_nth_capture: behavioural generator stub, table vectors,
// directed multi-cycle sequences and randomized requests against an arithmetic model.
module tb_fib_nth_capture;
    import fib_pkg::*;

    localparam int W  = 32;
    localparam int NW = 6;

    logic        clock;
    logic        reset;
    logic        gen_clear;
    logic [W-1:0] gen_value;
    state_t      state_dbg;

    fib_nth_capture_if #(.WIDTH(W), .NW(NW)) bus ();

    fib_nth_capture #(.WIDTH(W), .NW(NW), .MAX_N(47), .CLEAR_CYCLES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .gen_clear (gen_clear),
        .gen_value (gen_value),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- generator stub ----------------
    // Reset value shows F(1)=1, then advances one term per clock; freeze sticks it at 3.
    logic         gen_rst;
    logic [W-1:0] gen_cur, gen_nxt;
    logic         freeze;
    assign gen_rst   = reset | gen_clear;
    assign gen_value = gen_cur;

    always @(posedge clock or posedge gen_rst) begin
        if (gen_rst) begin
            gen_cur <= 32'd1;
            gen_nxt <= 32'd1;
        end else if (!(freeze && gen_cur >= 32'd3)) begin
            gen_cur <= gen_nxt;
            gen_nxt <= gen_cur + gen_nxt;
        end
    end

    int clear_cnt;
    always @(negedge clock) if (gen_clear) clear_cnt++;

    // ---------------- scoreboard ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: F(n) by plain iteration, F(0)=0, F(1)=1.
    function automatic longint unsigned fib(input int k);
        longint unsigned a = 0, b = 1, t;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Latency counted in rising edges after the edge that samples start.
    function automatic void model(input int k, output longint unsigned r, output int e,
                                  output int lat, output int clr);
        if (k == 0)       begin r = 0;      e = 0; lat = 0;     clr = 0; end
        else if (k > 47)  begin r = 0;      e = 1; lat = 0;     clr = 0; end
        else              begin r = fib(k); e = 0; lat = 2 + k; clr = 2; end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.n = '0;
        bus.result_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic issue(input logic [NW-1:0] nv, output int lat, output logic ok);
        @(negedge clock);
        clear_cnt = 0;
        bus.start = 1'b1;
        bus.n = nv;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        lat = 0;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bus.result_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            lat++;
        end
    endtask

    typedef struct {
        logic [NW-1:0] n;
        logic [W-1:0]  exp_result;
        logic [1:0]    exp_err;
        int            exp_lat;
        int            exp_clr;
    } vec_t;

    vec_t vecs[7];

    int   lat;
    logic ok;
    logic [W-1:0] held;

    initial begin
        vecs[0] = '{6'd10, 32'd55,         2'd0, 12, 2};
        vecs[1] = '{6'd0,  32'd0,          2'd0, 0,  0};
        vecs[2] = '{6'd47, 32'hB11924E1,   2'd0, 49, 2};
        vecs[3] = '{6'd48, 32'd0,          2'd1, 0,  0};
        vecs[4] = '{6'd1,  32'd1,          2'd0, 3,  2};
        vecs[5] = '{6'd2,  32'd1,          2'd0, 4,  2};
        vecs[6] = '{6'd63, 32'd0,          2'd1, 0,  0};

        freeze = 1'b0;
        clear_cnt = 0;
        do_reset();

        check("rst.busy",   64'(bus.busy),         64'd0);
        check("rst.valid",  64'(bus.result_valid), 64'd0);
        check("rst.clear",  64'(gen_clear),        64'd0);
        check("rst.result", 64'(bus.result),       64'd0);
        check("rst.err",    64'(bus.err),          64'd0);
        check("rst.state",  64'(state_dbg),        64'(IDLE));

        // ---- table vectors, consumer always ready ----
        bus.result_ready = 1'b1;
        foreach (vecs[i]) begin
            issue(vecs[i].n, lat, ok);
            check($sformatf("vec%0d.done", i),   64'(ok),         64'd1);
            check($sformatf("vec%0d.result", i), 64'(bus.result), 64'(vecs[i].exp_result));
            check($sformatf("vec%0d.err", i),    64'(bus.err),    64'(vecs[i].exp_err));
            check($sformatf("vec%0d.lat", i),    64'(lat),        64'(vecs[i].exp_lat));
            check($sformatf("vec%0d.clear", i),  64'(clear_cnt),  64'(vecs[i].exp_clr));
            @(negedge clock);
            check($sformatf("vec%0d.busy_after", i),  64'(bus.busy),         64'd0);
            check($sformatf("vec%0d.valid_after", i), 64'(bus.result_valid), 64'd0);
        end

        // ---- stalled consumer, stray starts ignored ----
        bus.result_ready = 1'b0;
        issue(6'd5, lat, ok);
        check("hold.done",   64'(ok),         64'd1);
        check("hold.lat",    64'(lat),        64'd7);
        check("hold.result", 64'(bus.result), 64'd5);
        for (int c = 0; c < 6; c++) begin
            bus.start = (c == 2);
            bus.n = 6'd3;
            @(negedge clock);
            check($sformatf("hold.valid%0d", c),  64'(bus.result_valid), 64'd1);
            check($sformatf("hold.result%0d", c), 64'(bus.result),       64'd5);
        end
        // start coincident with the handshake edge
        bus.start = 1'b1;
        bus.n = 6'd7;
        bus.result_ready = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check("hold.release_valid", 64'(bus.result_valid), 64'd0);
        check("hold.release_busy",  64'(bus.busy),         64'd0);
        @(negedge clock);
        check("hold.not_queued", 64'(bus.busy), 64'd0);

        // ---- reset during RUN ----
        @(negedge clock);
        bus.start = 1'b1;
        bus.n = 6'd20;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (6) @(negedge clock);
        check("mid.state_run", 64'(state_dbg), 64'(RUN));
        #2 reset = 1'b1;
        #1;
        check("mid.busy",  64'(bus.busy),         64'd0);
        check("mid.valid", 64'(bus.result_valid), 64'd0);
        check("mid.clear", 64'(gen_clear),        64'd0);
        check("mid.state", 64'(state_dbg),        64'(IDLE));
        @(negedge clock);
        reset = 1'b0;
        issue(6'd20, lat, ok);
        check("mid.redo_done",   64'(ok),         64'd1);
        check("mid.redo_result", 64'(bus.result), 64'd6765);
        check("mid.redo_clear",  64'(clear_cnt),  64'd2);
        check("mid.redo_lat",    64'(lat),        64'd22);
        @(negedge clock);

        // ---- generator stuck at 3 ----
        freeze = 1'b1;
        issue(6'd10, lat, ok);
        check("stuck.done",   64'(ok),         64'd1);
        check("stuck.err",    64'(bus.err),    64'd2);
        check("stuck.result", 64'(bus.result), 64'd3);
        check("stuck.lat",    64'(lat),        64'd7);
        @(negedge clock);
        freeze = 1'b0;

        // ---- randomized requests against the model ----
        for (int t = 0; t < 20; t++) begin
            logic [NW-1:0]   nv;
            longint unsigned r;
            int              e, el, ec, d;
            nv = NW'($urandom_range(0, 63));
            d  = $urandom_range(0, 3);
            model(int'(nv), r, e, el, ec);
            bus.result_ready = 1'b0;
            issue(nv, lat, ok);
            check($sformatf("rnd%0d.done n=%0d", t, nv),  64'(ok),        64'd1);
            check($sformatf("rnd%0d.err n=%0d", t, nv),   64'(bus.err),   64'(e));
            check($sformatf("rnd%0d.lat n=%0d", t, nv),   64'(lat),       64'(el));
            check($sformatf("rnd%0d.clear n=%0d", t, nv), 64'(clear_cnt), 64'(ec));
            held = bus.result;
            repeat (d) @(negedge clock);
            check($sformatf("rnd%0d.result n=%0d", t, nv), 64'(bus.result),       r);
            check($sformatf("rnd%0d.stable n=%0d", t, nv), 64'(bus.result),       64'(held));
            check($sformatf("rnd%0d.valid n=%0d", t, nv),  64'(bus.result_valid), 64'd1);
            bus.result_ready = 1'b1;
            @(negedge clock);
            check($sformatf("rnd%0d.done_valid n=%0d", t, nv), 64'(bus.result_valid), 64'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
